// File: rtl/axis_collect.sv
// Purpose: gathers one word per input channel into one packed output word (skew monitor under AXIS_COLLECT_SKEW_CNT_EN).
// Latency: last channel frames at edge k, m_axis_tvalid high after edge k+1 (registered output).
// Backpressure: full slots hold with tready=0 while the output is stalled; empty slots still take one word each.
module axis_collect #(
    parameter int NUM_COLLECT = 6,
    parameter int DATA_WIDTH  = 128,
    parameter int SKEW_LIMIT  = 1024
) (
    input  logic                              s_axis_clk,
    input  logic                              s_axis_rstn,
    input  logic [NUM_COLLECT-1:0]            s_axis_tvalid,
    output logic [NUM_COLLECT-1:0]            s_axis_tready,
    input  logic [NUM_COLLECT*DATA_WIDTH-1:0] s_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [NUM_COLLECT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [31:0]                       skew_max,
    output logic                              skew_err
);
    localparam int N = NUM_COLLECT;
    localparam int W = DATA_WIDTH;
    localparam logic [31:0] SKEW_LIM = SKEW_LIMIT[31:0];

    logic [N-1:0]        held_q, held_d;
    logic [N-1:0][W-1:0] slot_q, slot_d;
    logic                out_valid_q, out_valid_d;
    logic [N*W-1:0]      out_data_q, out_data_d;
    logic                xfer;
    logic [N-1:0]        frame;

    always_comb begin
        xfer          = (&held_q) & (~out_valid_q | m_axis_tready);
        s_axis_tready = ~held_q | {N{xfer}};
        frame         = s_axis_tvalid & s_axis_tready;

        held_d = held_q;
        slot_d = slot_q;
        if (xfer) begin
            held_d = '0;
        end
        // A new word landing on the transfer cycle refills the slot for the next set.
        for (int n = 0; n < N; n++) begin
            if (frame[n]) begin
                held_d[n] = 1'b1;
                slot_d[n] = s_axis_tdata[n*W +: W];
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = slot_q;
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
        if (!s_axis_rstn) begin
            held_q      <= '0;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            held_q      <= held_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;

`ifdef AXIS_COLLECT_SKEW_CNT_EN
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] max_q, max_d;
    logic        run_q, run_d;
    logic        err_q, err_d;
    logic        set_start;

    always_comb begin
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
        // A set begins when a word arrives while no set is pending in the slots.
        set_start = (~(|held_q) | xfer) & (|frame);
        cnt_d     = cnt_q;
        max_d     = max_q;
        run_d     = run_q;
        err_d     = err_q;
        if (run_q) begin
            cnt_d = cnt_inc;
            if (&held_d) begin
                run_d = 1'b0;
                if (cnt_inc > max_q) begin
                    max_d = cnt_inc;
                end
                if (cnt_inc > SKEW_LIM) begin
                    err_d = 1'b1;
                end
            end
        end else if (set_start) begin
            cnt_d = '0;
            run_d = ~(&held_d);
        end
    end

    always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
        if (!s_axis_rstn) begin
            cnt_q <= '0;
            max_q <= '0;
            run_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
            run_q <= run_d;
            err_q <= err_d;
        end
    end

    assign skew_max = max_q;
    assign skew_err = err_q;
`else
    logic unused_skew;
    assign unused_skew = ^SKEW_LIM;
    assign skew_max    = '0;
    assign skew_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_collect.sv
// Directed bench for axis_collect with N=4, W=8, SKEW_LIMIT=4.
module tb_axis_collect;
`ifdef AXIS_COLLECT_SKEW_CNT_EN
    localparam bit SKEW_ON = 1'b1;
`else
    localparam bit SKEW_ON = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [3:0]  tvalid;
    logic [3:0]  tready;
    logic [31:0] tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [31:0] skew_max;
    logic        skew_err;

    int ncmp  = 0;
    int nfail = 0;

    axis_collect #(.NUM_COLLECT(4), .DATA_WIDTH(8), .SKEW_LIMIT(4)) dut (
        .s_axis_clk   (clk),
        .s_axis_rstn  (rstn),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .s_axis_tdata (tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata (m_tdata),
        .skew_max     (skew_max),
        .skew_err     (skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // ch0 frames at edge 0, ch1..3 at edge d
    task automatic skew_set(input int d, input logic [31:0] dat);
        tvalid = 4'h1;
        tdata  = dat;
        tick();
        tvalid = 4'h0;
        for (int i = 1; i < d; i++) begin
            chk("skew_rdy0", tready[0], 1'b0);
            tick();
        end
        tvalid = 4'hE;
        chk("skew_rdy0_last", tready[0], 1'b0);
        tick();
        tvalid = 4'h0;
        chk("skew_vld_early", m_tvalid, 1'b0);
        tick();
        chk("skew_vld", m_tvalid, 1'b1);
        chk("skew_dat", m_tdata, dat);
        tick();
    endtask

    function automatic logic [7:0] sbyte(input int n, input int j);
        return 8'((n << 6) | (j & 63));
    endfunction

    initial begin
        int          sent [4];
        logic [3:0]  acc;
        logic [31:0] exp_w;
        int          got;
        int          cyc;

        rstn     = 1'b0;
        tvalid   = 4'h0;
        tdata    = 32'h0;
        m_tready = 1'b1;
        #1;
        chk("rst_tready", tready, 4'hF);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_skew_max", skew_max, 32'h0);
        chk("rst_skew_err", skew_err, 1'b0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // aligned
        tvalid = 4'hF;
        tdata  = 32'h44332211;
        tick();
        tvalid = 4'h0;
        chk("align_vld0", m_tvalid, 1'b0);
        tick();
        chk("align_vld1", m_tvalid, 1'b1);
        chk("align_dat", m_tdata, 32'h44332211);
        tick();
        chk("align_vld2", m_tvalid, 1'b0);
        chk("align_skew", skew_max, 32'h0);

        // skew 4: at the limit, no error
        skew_set(4, 32'hA4A3A2A1);
        chk("skew4_max", skew_max, SKEW_ON ? 32'd4 : 32'd0);
        chk("skew4_err", skew_err, 1'b0);
        // skew 5: above the limit
        skew_set(5, 32'hB4B3B2B1);
        chk("skew5_max", skew_max, SKEW_ON ? 32'd5 : 32'd0);
        chk("skew5_err", skew_err, SKEW_ON);
        skew_set(2, 32'hC4C3C2C1);
        chk("skew_max_keep", skew_max, SKEW_ON ? 32'd5 : 32'd0);
        chk("skew_err_sticky", skew_err, SKEW_ON);

        // stall: output plus slots hold two words
        m_tready = 1'b0;
        tvalid   = 4'hF;
        tdata    = 32'h01010101;
        tick();
        tdata = 32'h02020202;
        chk("stall_rdy_xfer", tready, 4'hF);
        tick();
        tdata = 32'h03030303;
        for (int i = 0; i < 8; i++) begin
            chk("stall_rdy", tready, 4'h0);
            chk("stall_vld", m_tvalid, 1'b1);
            chk("stall_dat", m_tdata, 32'h01010101);
            tick();
        end
        tvalid   = 4'h0;
        m_tready = 1'b1;
        chk("rel_dat0", m_tdata, 32'h01010101);
        tick();
        chk("rel_vld1", m_tvalid, 1'b1);
        chk("rel_dat1", m_tdata, 32'h02020202);
        tick();
        chk("rel_vld2", m_tvalid, 1'b0);

        // mid-operation reset with out_valid=1 and two slots held
        m_tready = 1'b0;
        tvalid   = 4'hF;
        tdata    = 32'h0D0C0B0A;
        tick();
        tvalid = 4'h0;
        tick();
        tvalid = 4'h3;
        tdata  = 32'h00002221;
        tick();
        tvalid = 4'h0;
        chk("pre_rst_vld", m_tvalid, 1'b1);
        chk("pre_rst_rdy", tready, 4'hC);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_vld", m_tvalid, 1'b0);
        chk("arst_dat", m_tdata, 32'h0);
        chk("arst_rdy", tready, 4'hF);
        chk("arst_skew_max", skew_max, 32'h0);
        chk("arst_skew_err", skew_err, 1'b0);
        tick();
        rstn     = 1'b1;
        m_tready = 1'b1;
        chk("post_rst_rdy", tready, 4'hF);
        tvalid = 4'hF;
        tdata  = 32'h5A6B7C8D;
        tick();
        tvalid = 4'h0;
        tick();
        chk("post_rst_vld", m_tvalid, 1'b1);
        chk("post_rst_dat", m_tdata, 32'h5A6B7C8D);
        tick();

        // streaming against a per-channel sequence scoreboard
        for (int n = 0; n < 4; n++) sent[n] = 0;
        acc = 4'h0;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            for (int n = 0; n < 4; n++) begin
                if (acc[n]) sent[n]++;
                if (!tvalid[n] || acc[n])
                    tvalid[n] = (sent[n] < 1000) && ($urandom_range(0, 9) < 7);
                tdata[n*8 +: 8] = sbyte(n, sent[n]);
            end
            m_tready = ($urandom_range(0, 3) != 0);
            #3;
            acc = tvalid & tready;
            if (m_tvalid && m_tready) begin
                for (int n = 0; n < 4; n++) exp_w[n*8 +: 8] = sbyte(n, got);
                chk("stream", m_tdata, exp_w);
                got++;
            end
            tick();
            cyc++;
        end
        tvalid = 4'h0;
        chk("stream_count", got, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
